// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit adder/subtractor: one operand bit pair per clock through a registered-carry
// full-adder slice. Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow output.
module serial_addsub_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             s_bit, c_next, last;

  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last   = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_next;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        if (last) begin
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_next;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // carry_q holds the carry into the MSB during the final step.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StShift && last) begin
      ovf_d = carry_q ^ c_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq: WIDTH=4 and WIDTH=8 instances driven side by side,
// each checked against an arithmetic reference model.
module tb_serial_addsub_seq;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_v[2];
  logic       sub_v[2];
  logic [7:0] a_v[2];
  logic [7:0] b_v[2];

  logic       busy4, done4, cout4, ovf4, busy8, done8, cout8, ovf8;
  logic [3:0] sum4;
  logic [7:0] sum8;

  logic       busy_v[2], done_v[2], cout_v[2], ovf_v[2];
  logic [7:0] sum_v[2];

  assign busy_v[0] = busy4;
  assign busy_v[1] = busy8;
  assign done_v[0] = done4;
  assign done_v[1] = done8;
  assign cout_v[0] = cout4;
  assign cout_v[1] = cout8;
  assign ovf_v[0]  = ovf4;
  assign ovf_v[1]  = ovf8;
  assign sum_v[0]  = {4'h0, sum4};
  assign sum_v[1]  = sum8;

  serial_addsub_seq #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_v[0]),
    .sub   (sub_v[0]),
    .a     (a_v[0][3:0]),
    .b     (b_v[0][3:0]),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  serial_addsub_seq #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_v[1]),
    .sub   (sub_v[1]),
    .a     (a_v[1]),
    .b     (b_v[1]),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  exp_t sb_q[2][$];
  int   busy_left[2];
  bit   done_exp[2];
  exp_t held[2];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   fin_req = 1'b0;

  function automatic int wid(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  // Plain integer arithmetic: unsigned result/carry and signed range check.
  function automatic exp_t ref_op(int w, logic [7:0] av, logic [7:0] bv, logic sb);
    int   mask, ua, ub, full, lim, sa, sbb, r;
    exp_t e;
    mask  = (1 << w) - 1;
    ua    = int'(av) & mask;
    ub    = int'(bv) & mask;
    full  = sb ? (ua + (~ub & mask) + 1) : (ua + ub);
    lim   = 1 << (w - 1);
    sa    = (ua >= lim) ? ua - 2 * lim : ua;
    sbb   = (ub >= lim) ? ub - 2 * lim : ub;
    r     = sb ? (sa - sbb) : (sa + sbb);
    e.sum  = 8'(full & mask);
    e.cout = ((full >> w) & 1) != 0;
    e.ovf  = OvfEn && ((r < -lim) || (r >= lim));
    return e;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s w%0d: got %0h expected %0h at %0t", nm, wid(i), act, exp, $time);
    end
  endtask

  // Reference model: an op occupies the block for WIDTH edges, then done follows.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        sb_q[i].delete();
        busy_left[i] = 0;
        done_exp[i]  = 1'b0;
      end else begin
        done_exp[i] = 1'b0;
        if (busy_left[i] > 0) begin
          busy_left[i]--;
          if (busy_left[i] == 0) done_exp[i] = 1'b1;
        end else if (start_v[i] === 1'b1) begin
          sb_q[i].push_back(ref_op(wid(i), a_v[i], b_v[i], sub_v[i]));
          busy_left[i] = wid(i);
        end
      end
    end
  end

  // Monitor: sole owner of the counters.
  always begin
    exp_t e;
    @(negedge clk or negedge rst_n);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        held[i] = '0;
        chk("rst_busy", i, 32'(busy_v[i]), 32'd0);
        chk("rst_done", i, 32'(done_v[i]), 32'd0);
        chk("rst_sum", i, 32'(sum_v[i]), 32'd0);
        chk("rst_cout", i, 32'(cout_v[i]), 32'd0);
        chk("rst_ovf", i, 32'(ovf_v[i]), 32'd0);
      end else begin
        chk("busy", i, 32'(busy_v[i]), 32'(busy_left[i] > 0));
        chk("done", i, 32'(done_v[i]), 32'(done_exp[i]));
        if (done_v[i] === 1'b1) begin
          if (sb_q[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done w%0d: got done=1 expected no pending op at %0t",
                     wid(i), $time);
          end else begin
            e = sb_q[i].pop_front();
            chk("sum", i, 32'(sum_v[i]), 32'(e.sum));
            chk("cout", i, 32'(cout_v[i]), 32'(e.cout));
            chk("ovf", i, 32'(ovf_v[i]), 32'(e.ovf));
            held[i] = e;
          end
        end else begin
          chk("hold_sum", i, 32'(sum_v[i]), 32'(held[i].sum));
          chk("hold_cout", i, 32'(cout_v[i]), 32'(held[i].cout));
          chk("hold_ovf", i, 32'(ovf_v[i]), 32'(held[i].ovf));
        end
      end
      if (fin_req) chk("drain", i, 32'(sb_q[i].size()), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int i, logic s, logic sb, logic [7:0] av, logic [7:0] bv);
    start_v[i] = s;
    sub_v[i]   = sb;
    a_v[i]     = av;
    b_v[i]     = bv;
  endtask

  task automatic op(int i, logic [7:0] av, logic [7:0] bv, logic sb);
    drv(i, 1'b1, sb, av, bv);
    tick();
    drv(i, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (wid(i) + 1) tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) drv(i, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases, including the boundaries.
    op(0, 8'd3, 8'd5, 1'b0);
    op(0, 8'd15, 8'd1, 1'b0);
    op(0, 8'd7, 8'd3, 1'b1);
    op(0, 8'd3, 8'd7, 1'b1);
    op(0, 8'd0, 8'd0, 1'b1);
    op(0, 8'd8, 8'd1, 1'b1);
    op(1, 8'hFF, 8'h01, 1'b1);
    op(1, 8'hFF, 8'h01, 1'b0);
    op(1, 8'h7F, 8'h01, 1'b0);

    // start held high with changing operands: back-to-back, start in SHIFT ignored.
    repeat (24) begin
      for (int i = 0; i < 2; i++)
        drv(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      tick();
    end
    for (int i = 0; i < 2; i++) drv(i, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (10) tick();

    // Random start density and operands.
    repeat (400) begin
      for (int i = 0; i < 2; i++)
        drv(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom));
      tick();
    end
    for (int i = 0; i < 2; i++) drv(i, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (10) tick();

    // Asynchronous reset two bits into an op: aborted, no done, then a clean op.
    drv(0, 1'b1, 1'b0, 8'd9, 8'd4);
    drv(1, 1'b1, 1'b1, 8'd200, 8'd13);
    tick();
    for (int i = 0; i < 2; i++) drv(i, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    op(0, 8'd6, 8'd6, 1'b0);
    op(1, 8'd6, 8'd6, 1'b0);

    repeat (3) tick();
    fin_req = 1'b1;
    @(negedge clk);
    #3;
    fin_req = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
